// File: rtl/shiftreg_feeder.sv
// shiftreg_feeder: accepts an n-bit word over a LOAD/READY handshake and
// streams it LSB-first on SOUT with an EN strobe, so that a downstream
// right-shifting register (serial input at its MSB) holds the word after
// n strobed edges. A one-entry holding buffer lets the next word queue up
// while the current frame shifts, and GAP idle cycles separate frames.
module shiftreg_feeder #(
    parameter int n   = 4,
    parameter int GAP = 1
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [n-1:0] DIN,
    input  logic         LOAD,
    output logic         READY,
    output logic         EN,
    output logic         SOUT,
    output logic         BUSY,
    output logic         DONE
);

    localparam int CW = $clog2(n);
    // A zero-length gap still needs a legal (unused) one-bit counter.
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(n - 1);
    localparam logic [GW-1:0] GCNT_LAST = (GAP > 0) ? GW'(GAP - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [n-1:0]    hold;
    logic            hold_v;
    logic [n-1:0]    sr;
    logic [CW-1:0]   cnt;
    logic [GW-1:0]   gcnt;
    logic            done_r;

    // Decoded actions for the current cycle.
    logic            reload;
    logic            shift;
    logic            frame_end;
    logic            gap_clr;
    logic            gap_inc;
    logic            accept;

    // READY depends on the holding flag only, so LOAD never reaches an output.
    assign accept = LOAD && !hold_v;

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state decode and per-cycle datapath actions.
    always_comb begin
        state_n   = state;
        reload    = 1'b0;
        shift     = 1'b0;
        frame_end = 1'b0;
        gap_clr   = 1'b0;
        gap_inc   = 1'b0;
        case (state)
            S_IDLE: begin
                if (hold_v) begin
                    reload  = 1'b1;
                    state_n = S_SHIFT;
                end
            end
            S_SHIFT: begin
                shift = 1'b1;
                if (cnt == CNT_LAST) begin
                    frame_end = 1'b1;
                    if (GAP > 0) begin
                        gap_clr = 1'b1;
                        state_n = S_GAP;
                    end else if (hold_v) begin
                        // Zero gap: next word follows with EN held high.
                        reload = 1'b1;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            S_GAP: begin
                gap_inc = 1'b1;
                if (gcnt == GCNT_LAST) begin
                    if (hold_v) begin
                        reload  = 1'b1;
                        state_n = S_SHIFT;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Holding buffer: filled on an accepted LOAD, emptied by a reload.
    // The two never coincide because accept needs hold_v low and reload
    // needs it high, so a word offered on the reload edge is not taken.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hold   <= '0;
            hold_v <= 1'b0;
        end else if (accept) begin
            hold   <= DIN;
            hold_v <= 1'b1;
        end else if (reload) begin
            hold_v <= 1'b0;
        end
    end

    // Shift word and bit counter.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sr  <= '0;
            cnt <= '0;
        end else if (reload) begin
            sr  <= hold;
            cnt <= '0;
        end else if (shift) begin
            sr  <= sr >> 1;
            cnt <= cnt + 1'b1;
        end
    end

    // Inter-frame gap counter.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            gcnt <= '0;
        end else if (gap_clr) begin
            gcnt <= '0;
        end else if (gap_inc) begin
            gcnt <= gcnt + 1'b1;
        end
    end

    // One-cycle DONE pulse following the last strobed bit of a frame.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            done_r <= 1'b0;
        end else begin
            done_r <= frame_end;
        end
    end

    assign READY = !hold_v;
    assign EN    = (state == S_SHIFT);
    assign SOUT  = sr[0];
    assign BUSY  = (state != S_IDLE) || hold_v;
    assign DONE  = done_r;

endmodule

// File: tb/tb_shiftreg_feeder.sv
// Directed bench for shiftreg_feeder: one instance with GAP=1, one with
// GAP=0, each followed by a model of the downstream 4-bit shift register.
module tb_shiftreg_feeder;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [3:0] din1 = '0;
    logic [3:0] din0 = '0;
    logic       load1 = 1'b0;
    logic       load0 = 1'b0;
    logic       ready1, en1, sout1, busy1, done1;
    logic       ready0, en0, sout0, busy0, done0;
    logic [3:0] ds1 = '0;
    logic [3:0] ds0 = '0;
    int         total = 0;
    int         bad = 0;

    shiftreg_feeder #(.n(4), .GAP(1)) dut1 (
        .CLK(CLK), .RST(RST), .DIN(din1), .LOAD(load1),
        .READY(ready1), .EN(en1), .SOUT(sout1), .BUSY(busy1), .DONE(done1)
    );

    shiftreg_feeder #(.n(4), .GAP(0)) dut0 (
        .CLK(CLK), .RST(RST), .DIN(din0), .LOAD(load0),
        .READY(ready0), .EN(en0), .SOUT(sout0), .BUSY(busy0), .DONE(done0)
    );

    always #5 CLK = ~CLK;

    // Downstream registers: shift right, serial input enters at the MSB.
    always @(posedge CLK) if (en1) ds1 <= {sout1, ds1[3:1]};
    always @(posedge CLK) if (en0) ds0 <= {sout0, ds0[3:1]};

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        #1;
        total++;
        if ({en1, sout1, ready1, busy1, done1} !== 5'b00100) begin
            bad++;
            $display("FAIL reset_g1 {en,sout,ready,busy,done}=%b want 00100",
                     {en1, sout1, ready1, busy1, done1});
        end
        total++;
        if ({en0, sout0, ready0, busy0, done0} !== 5'b00100) begin
            bad++;
            $display("FAIL reset_g0 {en,sout,ready,busy,done}=%b want 00100",
                     {en0, sout0, ready0, busy0, done0});
        end
        step();
        RST = 1'b0;
        step();
        step();
        // Start a frame, then assert reset between edges while it shifts.
        din1 = 4'b1111;
        load1 = 1'b1;
        step();
        load1 = 1'b0;
        step();
        step();
        total++;
        if ({en1, sout1, busy1} !== 3'b111) begin
            bad++;
            $display("FAIL pre_reset_shift {en,sout,busy}=%b want 111", {en1, sout1, busy1});
        end
        #2;
        RST = 1'b1;
        #1;
        total++;
        if ({en1, sout1, ready1, busy1, done1} !== 5'b00100) begin
            bad++;
            $display("FAIL async_reset {en,sout,ready,busy,done}=%b want 00100",
                     {en1, sout1, ready1, busy1, done1});
        end
        step();
        RST = 1'b0;
        step();
        total++;
        if ({en1, busy1, done1} !== 3'b000) begin
            bad++;
            $display("FAIL post_reset_idle {en,busy,done}=%b want 000", {en1, busy1, done1});
        end
    endtask

    task automatic test_single();
        logic [3:0] w;
        logic       xen, xdone, xready;
        w = 4'b0110;
        din1 = w;
        load1 = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            step();
            if (c == 1) load1 = 1'b0;
            xen    = (c >= 2 && c <= 5);
            xdone  = (c == 6);
            xready = (c != 1);
            total++;
            if ({en1, done1, ready1} !== {xen, xdone, xready}) begin
                bad++;
                $display("FAIL single_ctl cycle %0d {en,done,ready}=%b want %b",
                         c, {en1, done1, ready1}, {xen, xdone, xready});
            end
            if (xen) begin
                total++;
                if (sout1 !== w[c-2]) begin
                    bad++;
                    $display("FAIL single_sout cycle %0d got %b want %b", c, sout1, w[c-2]);
                end
            end
            if (c == 6) begin
                total++;
                if (ds1 !== w) begin
                    bad++;
                    $display("FAIL single_downstream got %b want %b", ds1, w);
                end
            end
            if (c == 7) begin
                total++;
                if (busy1 !== 1'b0) begin
                    bad++;
                    $display("FAIL single_busy_end got %b want 0", busy1);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] a, b;
        logic       xen, xdone, xready, xs;
        a = 4'b0011;
        b = 4'b1001;
        din1 = a;
        load1 = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            step();
            if (c == 1) load1 = 1'b0;
            if (c == 2) begin
                din1 = b;
                load1 = 1'b1;
            end
            if (c == 3) load1 = 1'b0;
            xen    = (c >= 2 && c <= 5) || (c >= 7 && c <= 10);
            xdone  = (c == 6) || (c == 11);
            xready = (c == 2) || (c >= 7);
            total++;
            if ({en1, done1, ready1} !== {xen, xdone, xready}) begin
                bad++;
                $display("FAIL b2b_ctl cycle %0d {en,done,ready}=%b want %b",
                         c, {en1, done1, ready1}, {xen, xdone, xready});
            end
            if (xen) begin
                xs = (c <= 5) ? a[c-2] : b[c-7];
                total++;
                if (sout1 !== xs) begin
                    bad++;
                    $display("FAIL b2b_sout cycle %0d got %b want %b", c, sout1, xs);
                end
            end
            if (c == 6 || c == 11) begin
                total++;
                if (ds1 !== ((c == 6) ? a : b)) begin
                    bad++;
                    $display("FAIL b2b_downstream cycle %0d got %b want %b",
                             c, ds1, (c == 6) ? a : b);
                end
            end
            if (c == 12) begin
                total++;
                if (busy1 !== 1'b0) begin
                    bad++;
                    $display("FAIL b2b_busy_end got %b want 0", busy1);
                end
            end
        end
    endtask

    task automatic test_gap0();
        logic [3:0] a, b;
        logic       xen, xdone, xready, xs;
        a = 4'b0011;
        b = 4'b1001;
        din0 = a;
        load0 = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            step();
            if (c == 1) load0 = 1'b0;
            if (c == 2) begin
                din0 = b;
                load0 = 1'b1;
            end
            if (c == 3) load0 = 1'b0;
            xen    = (c >= 2 && c <= 9);
            xdone  = (c == 6) || (c == 10);
            xready = (c == 2) || (c >= 6);
            total++;
            if ({en0, done0, ready0} !== {xen, xdone, xready}) begin
                bad++;
                $display("FAIL gap0_ctl cycle %0d {en,done,ready}=%b want %b",
                         c, {en0, done0, ready0}, {xen, xdone, xready});
            end
            if (xen) begin
                xs = (c <= 5) ? a[c-2] : b[c-6];
                total++;
                if (sout0 !== xs) begin
                    bad++;
                    $display("FAIL gap0_sout cycle %0d got %b want %b", c, sout0, xs);
                end
            end
            if (c == 6 || c == 10) begin
                total++;
                if (ds0 !== ((c == 6) ? a : b)) begin
                    bad++;
                    $display("FAIL gap0_downstream cycle %0d got %b want %b",
                             c, ds0, (c == 6) ? a : b);
                end
            end
            if (c == 11) begin
                total++;
                if (busy0 !== 1'b0) begin
                    bad++;
                    $display("FAIL gap0_busy_end got %b want 0", busy0);
                end
            end
        end
    endtask

    task automatic test_overrun();
        logic [3:0] a, b;
        logic       xen, xdone, xready, xs;
        a = 4'b0101;
        b = 4'b1010;
        din1 = a;
        load1 = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            step();
            if (c == 1) load1 = 1'b0;
            if (c == 2) begin
                din1 = b;
                load1 = 1'b1;
            end
            // Hold an unwanted word on LOAD through the reload edge.
            if (c == 3) din1 = 4'b1111;
            if (c == 7) load1 = 1'b0;
            xen    = (c >= 2 && c <= 5) || (c >= 7 && c <= 10);
            xdone  = (c == 6) || (c == 11);
            xready = (c == 2) || (c >= 7);
            total++;
            if ({en1, done1, ready1} !== {xen, xdone, xready}) begin
                bad++;
                $display("FAIL overrun_ctl cycle %0d {en,done,ready}=%b want %b",
                         c, {en1, done1, ready1}, {xen, xdone, xready});
            end
            if (xen) begin
                xs = (c <= 5) ? a[c-2] : b[c-7];
                total++;
                if (sout1 !== xs) begin
                    bad++;
                    $display("FAIL overrun_sout cycle %0d got %b want %b", c, sout1, xs);
                end
            end
            if (c == 11) begin
                total++;
                if (ds1 !== b) begin
                    bad++;
                    $display("FAIL overrun_downstream got %b want %b", ds1, b);
                end
            end
            if (c == 12) begin
                total++;
                if (busy1 !== 1'b0) begin
                    bad++;
                    $display("FAIL overrun_busy_end got %b want 0", busy1);
                end
            end
        end
    endtask

    task automatic test_mid_frame_reset();
        logic [3:0] w, saved;
        logic       xen;
        din1 = 4'b0110;
        load1 = 1'b1;
        step();
        load1 = 1'b0;
        step();
        din1 = 4'b1111;
        load1 = 1'b1;
        step();
        load1 = 1'b0;
        total++;
        if ({en1, busy1, ready1} !== 3'b110) begin
            bad++;
            $display("FAIL midreset_pre {en,busy,ready}=%b want 110", {en1, busy1, ready1});
        end
        #2;
        RST = 1'b1;
        #1;
        total++;
        if ({en1, busy1, ready1, done1} !== 4'b0010) begin
            bad++;
            $display("FAIL midreset_async {en,busy,ready,done}=%b want 0010",
                     {en1, busy1, ready1, done1});
        end
        saved = ds1;
        step();
        RST = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            total++;
            if ({en1, done1, busy1} !== 3'b000) begin
                bad++;
                $display("FAIL midreset_quiet step %0d {en,done,busy}=%b want 000",
                         k, {en1, done1, busy1});
            end
        end
        total++;
        if (ds1 !== saved) begin
            bad++;
            $display("FAIL midreset_downstream_kept got %b want %b", ds1, saved);
        end
        // Fresh word after release follows normal latency.
        w = 4'b1001;
        din1 = w;
        load1 = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            step();
            if (c == 1) load1 = 1'b0;
            xen = (c >= 2 && c <= 5);
            total++;
            if ({en1, done1} !== {xen, (c == 6)}) begin
                bad++;
                $display("FAIL restart_ctl cycle %0d {en,done}=%b want %b",
                         c, {en1, done1}, {xen, (c == 6)});
            end
            if (xen) begin
                total++;
                if (sout1 !== w[c-2]) begin
                    bad++;
                    $display("FAIL restart_sout cycle %0d got %b want %b", c, sout1, w[c-2]);
                end
            end
            if (c == 6) begin
                total++;
                if (ds1 !== w) begin
                    bad++;
                    $display("FAIL restart_downstream got %b want %b", ds1, w);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        step();
        step();
        test_single();
        step();
        step();
        test_back_to_back();
        step();
        step();
        test_gap0();
        step();
        step();
        test_overrun();
        step();
        step();
        test_mid_frame_reset();
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shiftreg_feeder.md
# shiftreg_feeder

Parallel-to-serial feeder that sits directly upstream of the 4-bit serial shift register. It accepts an n-bit word over a valid/ready handshake and emits it LSB-first on a serial bit with an accompanying enable strobe. After exactly n strobed clocks, the downstream register's parallel output equals the word. A one-entry holding buffer allows back-to-back words, and a programmable idle gap separates frames.

## Interface
- n, default 4: word width and bits per frame (≥2).
- GAP, default 1: idle cycles inserted after each frame (0 = back-to-back frames).

- CLK  in  1  single clock; all state changes on posedge.
- RST  in  1  asynchronous, active-high reset.
- DIN  in  n  parallel word to transmit.
- LOAD  in  1  DIN valid; accepted at the posedge where LOAD && READY.
- READY  out  1  holding buffer empty; equals !HOLD_V.
- EN  out  1  serial strobe; drives the downstream register's EN; high only in SHIFT.
- SOUT  out  1  serial data bit; equals SR[0]; drives the downstream register's serial input.
- BUSY  out  1  (state != IDLE) || HOLD_V.
- DONE  out  1  one-cycle pulse in the cycle after a frame's last EN cycle.

## Operation
- Storage:
  - HOLD[n-1:0] plus HOLD_V: one-entry input buffer.
  - SR[n-1:0]: active shift word.
  - CNT: bit counter, width clog2(n).
  - GCNT: gap counter, width clog2(GAP+1).
- Handshake: READY = !HOLD_V, a function of registers only (no combinational path from LOAD). On LOAD && READY: HOLD <= DIN, HOLD_V <= 1. LOAD while READY = 0 is ignored; the word is dropped and HOLD is unchanged.
- **IDLE** (EN = 0): if HOLD_V, then SR <= HOLD, HOLD_V <= 0, CNT <= 0, and go to SHIFT.
- **SHIFT** (EN = 1, SOUT = SR[0]): each posedge SR <= SR >> 1 and CNT <= CNT + 1. On the edge where CNT == n-1, the frame ends and DONE <= 1. The next state is:
  - GAP if GAP > 0, with GCNT <= 0;
  - otherwise SHIFT with a reload from HOLD if HOLD_V;
  - otherwise IDLE.
- **GAP** (EN = 0): GCNT increments each edge. On the edge where GCNT == GAP-1, go to SHIFT with a reload if HOLD_V, else to IDLE.
- Reload (any state): SR <= HOLD, HOLD_V <= 0, CNT <= 0.
- Simultaneous reload and LOAD on one edge: the reload clears HOLD_V, but READY was 0 during that cycle, so LOAD is not accepted. There is no same-edge refill.
- HOLD refills while SHIFT/GAP run, because READY rises the cycle after a reload.
- Bit order: LSB first. The downstream register shifts right with the serial input entering at the MSB, so after n strobed edges its output equals the transmitted word.
- Reset (asynchronous, any time): state IDLE, SR = 0, HOLD = 0, HOLD_V = 0, CNT = 0, GCNT = 0, DONE = 0. Outputs read EN = 0, SOUT = 0, READY = 1, BUSY = 0.
  - Reset mid-frame aborts the frame: no DONE and no resumption. The pending word is discarded. The downstream register keeps its partial contents.

## Timing
- Cycle t is the interval after posedge t.
- LOAD high in cycle 0 (accepted at edge 1) gives:
  - HOLD_V = 1 in cycle 1;
  - EN = 1 in cycles 2..n+1, carrying SOUT = DIN[0..n-1];
  - DONE = 1 in cycle n+2.
- Acceptance-to-first-strobe latency is 1 cycle from the accepting edge, assuming the feeder is in IDLE.
- The downstream register samples at edges 3..n+2. Its output is valid from cycle n+2, aligned with DONE.
- Frame period with a pending word: n + GAP cycles. With GAP = 0, EN stays high continuously across frames.
- All outputs are register-derived; no combinational input-to-output paths.

## Test plan
- Reset: assert RST mid-cycle with no clock edge -> EN = 0, SOUT = 0, READY = 1, BUSY = 0, DONE = 0 immediately.
- Single frame, n = 4, GAP = 1: DIN = 4'b0110 with LOAD in cycle 0 -> EN high in cycles 2..5, SOUT = 0,1,1,0, DONE in cycle 6, downstream output = 0110 in cycle 6, READY = 1 throughout from cycle 2.
- Back-to-back, GAP = 1: load 4'b0011, then load 4'b1001 while the first frame is shifting -> second-frame EN in cycles 7..10, DONE in cycles 6 and 11, downstream output 0011 then 1001.
- GAP = 0 with two queued words -> EN continuously high for 8 cycles, SOUT = 1,1,0,0,1,0,0,1.
- Overrun: LOAD 4'b1111 while READY = 0 -> ignored; the next frame sent is the previously held word.
- Mid-frame reset: assert RST in cycle 3 of a frame -> EN drops immediately, no DONE, pending word lost. A fresh LOAD after release restarts with the normal 1-cycle latency.
